// File: rtl/frame_pixel_streamer.sv
// -----------------------------------------------------------------------------
// frame_pixel_streamer
//
// Raster-order pixel source. On a start request it reads one
// IMG_WIDTH x IMG_HEIGHT frame from a synchronous single-port frame RAM and
// emits it as a stream of signed pixels tagged with start-of-frame,
// end-of-line and end-of-frame. Optional idle gaps follow every row except the
// last, and a stall input pauses new RAM reads without dropping or reordering
// pixels that are already in flight.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   start      in   frame request, honoured only while idle
//   stall      in   hold off new RAM reads while high
//   mem_rd_en  out  registered RAM read strobe
//   mem_addr   out  registered RAM address (row*IMG_WIDTH+col)
//   mem_rdata  in   RAM data, valid the cycle after mem_rd_en
//   pixel_out  out  registered signed pixel (two's complement)
//   valid_out  out  pixel_out valid
//   sof        out  first pixel of the frame
//   eol        out  last pixel of each row
//   eof        out  last pixel of the frame
//   busy       out  frame in progress
//   done       out  one-cycle pulse once the frame has fully drained
// -----------------------------------------------------------------------------
module frame_pixel_streamer #(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_WIDTH  = 5,
    parameter int IMG_HEIGHT = 5,
    parameter int ADDR_WIDTH = $clog2(IMG_WIDTH * IMG_HEIGHT),
    parameter int ROW_GAP    = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stall,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [DATA_WIDTH-1:0] pixel_out,
    output logic                  valid_out,
    output logic                  sof,
    output logic                  eol,
    output logic                  eof,
    output logic                  busy,
    output logic                  done
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam logic [CW-1:0]         LAST_COL  = CW'(IMG_WIDTH - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(IMG_WIDTH * IMG_HEIGHT - 1);
    localparam logic [7:0]            GAP_LAST  = 8'(ROW_GAP - 1);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        GAP,
        DRAIN
    } state_t;

    state_t state_q, state_d;

    // Column counter drives eol/row wrap; the linear address counter tracks
    // row*IMG_WIDTH+col directly so no multiplier is needed.
    logic [CW-1:0]         col_q, col_d;
    logic [ADDR_WIDTH-1:0] nxt_q, nxt_d;
    logic [7:0]            gap_q, gap_d;

    // Stage 0: read issued to the RAM, with its tags.
    logic                  rd_en_q, rd_en_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  tsof_q, tsof_d;
    logic                  teol_q, teol_d;
    logic                  teof_q, teof_d;

    // Stage 1: RAM data returning, tags travelling alongside.
    logic                  v1_q;
    logic                  sof1_q, eol1_q, eof1_q;

    // Stage 2: registered outputs.
    logic                  valid_q;
    logic [DATA_WIDTH-1:0] pix_q;
    logic                  sof_q, eol_q, eof_q;
    logic                  done_q, done_d;

    logic                  issue;

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        nxt_d   = nxt_q;
        gap_d   = gap_q;
        rd_en_d = 1'b0;
        addr_d  = addr_q;
        tsof_d  = 1'b0;
        teol_d  = 1'b0;
        teof_d  = 1'b0;
        done_d  = 1'b0;
        issue   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = STREAM;
                    col_d   = '0;
                    nxt_d   = '0;
                    // First read goes out on the accepting edge so address 0
                    // appears in the very next cycle.
                    issue   = !stall;
                end
            end
            STREAM: begin
                issue = !stall;
            end
            GAP: begin
                gap_d = gap_q + 8'd1;
                if (gap_q == GAP_LAST) begin
                    state_d = STREAM;
                end
            end
            DRAIN: begin
                // Exit once nothing is left in the read or data-return stage;
                // the final pixel is on the outputs in this same cycle.
                if (!rd_en_q && !v1_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (issue) begin
            rd_en_d = 1'b1;
            addr_d  = nxt_d;
            tsof_d  = (nxt_d == '0);
            teol_d  = (col_d == LAST_COL);
            teof_d  = (nxt_d == LAST_ADDR);
            if (nxt_d == LAST_ADDR) begin
                state_d = DRAIN;
                col_d   = '0;
                nxt_d   = '0;
            end else begin
                nxt_d = nxt_d + ADDR_WIDTH'(1);
                if (col_d == LAST_COL) begin
                    col_d = '0;
                    if (ROW_GAP > 0) begin
                        state_d = GAP;
                        gap_d   = '0;
                    end
                end else begin
                    col_d = col_d + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            col_q   <= '0;
            nxt_q   <= '0;
            gap_q   <= '0;
            rd_en_q <= 1'b0;
            addr_q  <= '0;
            tsof_q  <= 1'b0;
            teol_q  <= 1'b0;
            teof_q  <= 1'b0;
            v1_q    <= 1'b0;
            sof1_q  <= 1'b0;
            eol1_q  <= 1'b0;
            eof1_q  <= 1'b0;
            valid_q <= 1'b0;
            pix_q   <= '0;
            sof_q   <= 1'b0;
            eol_q   <= 1'b0;
            eof_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            nxt_q   <= nxt_d;
            gap_q   <= gap_d;
            rd_en_q <= rd_en_d;
            addr_q  <= addr_d;
            tsof_q  <= tsof_d;
            teol_q  <= teol_d;
            teof_q  <= teof_d;
            v1_q    <= rd_en_q;
            sof1_q  <= tsof_q;
            eol1_q  <= teol_q;
            eof1_q  <= teof_q;
            valid_q <= v1_q;
            if (v1_q) begin
                pix_q <= mem_rdata;
            end
            sof_q   <= sof1_q;
            eol_q   <= eol1_q;
            eof_q   <= eof1_q;
            done_q  <= done_d;
        end
    end

    assign mem_rd_en = rd_en_q;
    assign mem_addr  = addr_q;
    assign pixel_out = pix_q;
    assign valid_out = valid_q;
    assign sof       = sof_q;
    assign eol       = eol_q;
    assign eof       = eof_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;

endmodule

// File: tb/tb_frame_pixel_streamer.sv
`timescale 1ns/1ps
module tb_frame_pixel_streamer;

    localparam int DW = 8;
    localparam int W  = 5;
    localparam int H  = 5;
    localparam int N  = W * H;
    localparam int AW = $clog2(N);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Index 0: ROW_GAP=0 instance, index 1: ROW_GAP=2 instance.
    logic [1:0] rst_v, start_v, stall_v;
    logic [1:0] rd_v, valid_v, sof_v, eol_v, eof_v, busy_v, done_v;
    logic [AW-1:0] addr_s [2];
    logic [DW-1:0] rdata_s [2];
    logic [DW-1:0] pix_s [2];
    logic [DW-1:0] ram [N];

    frame_pixel_streamer #(.DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H),
                           .ADDR_WIDTH(AW), .ROW_GAP(0)) u_dut0 (
        .clk(clk), .rst(rst_v[0]), .start(start_v[0]), .stall(stall_v[0]),
        .mem_rd_en(rd_v[0]), .mem_addr(addr_s[0]), .mem_rdata(rdata_s[0]),
        .pixel_out(pix_s[0]), .valid_out(valid_v[0]), .sof(sof_v[0]),
        .eol(eol_v[0]), .eof(eof_v[0]), .busy(busy_v[0]), .done(done_v[0]));

    frame_pixel_streamer #(.DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H),
                           .ADDR_WIDTH(AW), .ROW_GAP(2)) u_dut2 (
        .clk(clk), .rst(rst_v[1]), .start(start_v[1]), .stall(stall_v[1]),
        .mem_rd_en(rd_v[1]), .mem_addr(addr_s[1]), .mem_rdata(rdata_s[1]),
        .pixel_out(pix_s[1]), .valid_out(valid_v[1]), .sof(sof_v[1]),
        .eol(eol_v[1]), .eof(eof_v[1]), .busy(busy_v[1]), .done(done_v[1]));

    // Synchronous single-port frame RAMs (shared contents).
    always @(posedge clk) begin
        if (rd_v[0]) rdata_s[0] <= ram[addr_s[0]];
        if (rd_v[1]) rdata_s[1] <= ram[addr_s[1]];
    end

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int t0, first_v, done_at, npix, ndone;
    bit [127:0] vmask;

    // Reference model: expected outputs for the current cycle plus the
    // frame-level bookkeeping (pixels issued, remaining gap cycles).
    int m_rd[2], m_addr[2], m_v[2], m_va[2], m_v1[2], m_a1[2];
    int m_busy[2], m_done[2], f_act[2], issued[2], gl[2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset(input int d);
        m_rd[d] = 0; m_addr[d] = 0; m_v[d] = 0; m_va[d] = 0; m_v1[d] = 0;
        m_a1[d] = 0; m_busy[d] = 0; m_done[d] = 0; f_act[d] = 0;
        issued[d] = 0; gl[d] = 0;
    endtask

    task automatic clr_rec();
        t0 = cyc; first_v = -1; done_at = -1; npix = 0; ndone = 0; vmask = '0;
    endtask

    // Check the current cycle against the model, advance the model using the
    // inputs now applied, then move to the next cycle.
    task automatic tick(input int d);
        int rg, rel, n_v, n_va, n_v1, n_a1, n_rd, n_addr, n_done;
        bit can;
        rg  = (d == 0) ? 0 : 2;
        rel = cyc - t0;
        chk("rd_en", rd_v[d], m_rd[d]);
        chk("addr", addr_s[d], m_addr[d]);
        chk("valid", valid_v[d], m_v[d]);
        chk("busy", busy_v[d], m_busy[d]);
        chk("done", done_v[d], m_done[d]);
        if (m_v[d] != 0) begin
            chk("pixel", pix_s[d], ram[m_va[d]]);
            chk("sof", sof_v[d], m_va[d] == 0);
            chk("eol", eol_v[d], (m_va[d] % W) == W - 1);
            chk("eof", eof_v[d], m_va[d] == N - 1);
        end else begin
            chk("tags_idle", {sof_v[d], eol_v[d], eof_v[d]}, 0);
        end
        if (valid_v[d]) begin
            npix++;
            if (first_v < 0) first_v = rel;
        end
        if (rel >= 0 && rel < 128) vmask[rel] = valid_v[d];
        if (done_v[d]) begin
            done_at = rel;
            ndone++;
        end

        if (rst_v[d]) begin
            model_reset(d);
        end else begin
            n_v = m_v1[d]; n_va = m_a1[d]; n_v1 = m_rd[d]; n_a1 = m_addr[d];
            n_rd = 0; n_addr = m_addr[d]; n_done = 0; can = 0;
            if (f_act[d] == 0) begin
                if (start_v[d]) begin
                    f_act[d] = 1; issued[d] = 0; gl[d] = 0; can = 1;
                end
            end else if (m_v[d] != 0 && m_va[d] == N - 1) begin
                f_act[d] = 0; n_done = 1;
            end else begin
                can = (issued[d] < N);
            end
            if (can) begin
                if (gl[d] > 0) begin
                    gl[d]--;
                end else if (!stall_v[d]) begin
                    n_rd = 1; n_addr = issued[d]; issued[d]++;
                    if ((n_addr % W) == W - 1 && (n_addr / W) < H - 1) gl[d] = rg;
                end
            end
            m_v[d] = n_v; m_va[d] = n_va; m_v1[d] = n_v1; m_a1[d] = n_a1;
            m_rd[d] = n_rd; m_addr[d] = n_addr; m_done[d] = n_done;
            m_busy[d] = f_act[d];
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        rst_v = '1; start_v = '0; stall_v = '0;
        for (int a = 0; a < N; a++) ram[a] = DW'(a - 12);
        model_reset(0);
        model_reset(1);
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("reset_outs", {rd_v[d], valid_v[d], sof_v[d], eol_v[d], eof_v[d],
                               busy_v[d], done_v[d]}, 0);
            chk("reset_addr", addr_s[d], 0);
            chk("reset_pix", pix_s[d], 0);
        end
        rst_v = '0;
        tick(0);

        // Plain frame, no gaps, no stall.
        clr_rec();
        for (int k = 0; k < 36; k++) begin
            start_v[0] = (k == 0);
            tick(0);
        end
        chk("A_first_valid", first_v, 3);
        chk("A_done_cycle", done_at, 28);
        chk("A_npix", npix, 25);

        // Two idle cycles after each non-final row.
        clr_rec();
        for (int k = 0; k < 44; k++) begin
            start_v[1] = (k == 0);
            tick(1);
        end
        chk("B_done_cycle", done_at, 36);
        chk("B_npix", npix, 25);

        // Stall held for cycles 5..8.
        clr_rec();
        for (int k = 0; k < 40; k++) begin
            start_v[0] = (k == 0);
            stall_v[0] = (k >= 5 && k <= 8);
            tick(0);
        end
        chk("C_hole", vmask[12:6], 7'b1000011);
        chk("C_done_cycle", done_at, 32);
        chk("C_npix", npix, 25);

        // Start while busy is ignored; start on the done cycle is accepted.
        clr_rec();
        for (int k = 0; k < 70; k++) begin
            start_v[0] = (k == 0 || k == 10 || k == 28);
            tick(0);
        end
        chk("D_b2b", vmask[31:27], 5'b10001);
        chk("D_ndone", ndone, 2);
        chk("D_npix", npix, 50);

        // Reset in the middle of a frame.
        clr_rec();
        for (int k = 0; k < 20; k++) begin
            start_v[0] = (k == 0);
            if (k == 12) begin
                rst_v[0] = 1'b1;
                #1;
                chk("E_rst_outs", {rd_v[0], valid_v[0], busy_v[0], sof_v[0],
                                   eol_v[0], eof_v[0], done_v[0]}, 0);
                model_reset(0);
            end
            if (k == 13) rst_v[0] = 1'b0;
            tick(0);
        end
        chk("E_no_done", ndone, 0);

        // Randomised contents and stall after the reset.
        for (int a = 0; a < N; a++) ram[a] = DW'($urandom);
        clr_rec();
        for (int k = 0; k < 70; k++) begin
            start_v[0] = (k == 0);
            stall_v[0] = ($urandom_range(0, 3) == 0);
            tick(0);
        end
        stall_v[0] = 1'b0;
        chk("E_first_valid", first_v >= 3, 1);
        chk("E_npix", npix, 25);
        chk("E_ndone", ndone, 1);

        // Randomised contents and stall with row gaps, two frames.
        for (int f = 0; f < 2; f++) begin
            for (int a = 0; a < N; a++) ram[a] = DW'($urandom);
            clr_rec();
            for (int k = 0; k < 80; k++) begin
                start_v[1] = (k == 0);
                stall_v[1] = ($urandom_range(0, 2) == 0);
                tick(1);
            end
            stall_v[1] = 1'b0;
            chk("F_npix", npix, 25);
            chk("F_ndone", ndone, 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
